// File: rtl/phase_sequencer_pkg.sv
// Shared types and default sizing for the instruction phase sequencer.
// The CPU top reuses the default constants.
package phase_sequencer_pkg;

  localparam int unsigned DEF_PHASES = 3;
  localparam int unsigned DEF_WAIT_W = 4;
  localparam int unsigned DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/phase_wait_timer.sv
// Per-phase wait-state down-counter. It flags the advance cycle of a phase once
// the programmed waits have elapsed and no external stall is pending.
module phase_wait_timer
  import phase_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_W = DEF_WAIT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              ext_wait,
  output logic              last_c
);

  logic [WAIT_W-1:0] count;

  // ext_wait does not freeze the countdown; it only holds the phase once the count is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WAIT_W'(1);
    end
  end

  assign last_c = active && (count == '0) && !ext_wait;

endmodule

// File: rtl/phase_sequencer.sv
// Generates one-hot execution phases with per-phase wait states and an external stall.
// It also runs the run/halt/single-step control and counts retired instructions.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int unsigned PHASES = DEF_PHASES,
  parameter int unsigned WAIT_W = DEF_WAIT_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  localparam int unsigned IDX_W = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     halt_req,
  input  logic                     step_req,
  input  logic                     ext_wait,
  input  logic [PHASES*WAIT_W-1:0] wait_cfg,
  output logic [PHASES-1:0]        phase,
  output logic [IDX_W-1:0]         phase_idx,
  output logic                     phase_last,
  output logic                     cycle_done,
  output logic [CNT_W-1:0]         instr_count,
  output logic                     halted
);

  seq_state_t        state, state_n;
  logic [PHASES-1:0] phase_n;
  logic [IDX_W-1:0]  phase_idx_n;
  logic              cycle_done_n;
  logic [CNT_W-1:0]  instr_count_n;
  logic              halted_n;
  logic              timer_load;
  logic [IDX_W-1:0]  load_idx;
  logic [WAIT_W-1:0] load_val;
  logic              active;

  assign active   = (state != ST_HALT);
  assign load_val = wait_cfg[32'(load_idx) * WAIT_W +: WAIT_W];

  phase_wait_timer #(
    .WAIT_W (WAIT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .active   (active),
    .load     (timer_load),
    .load_val (load_val),
    .ext_wait (ext_wait),
    .last_c   (phase_last)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_n       = state;
    phase_n       = phase;
    phase_idx_n   = phase_idx;
    cycle_done_n  = 1'b0;
    instr_count_n = instr_count;
    halted_n      = halted;
    timer_load    = 1'b0;
    load_idx      = '0;

    case (state)
      ST_HALT: begin
        if (run || step_req) begin
          state_n     = run ? ST_RUN : ST_STEP;
          phase_n     = PHASES'(1);
          phase_idx_n = '0;
          halted_n    = 1'b0;
          timer_load  = 1'b1;
        end
      end
      ST_RUN, ST_STEP: begin
        if (phase_last) begin
          if (phase_idx == IDX_W'(PHASES - 1)) begin
            // Instruction boundary: retire and decide whether to keep running
            cycle_done_n  = 1'b1;
            instr_count_n = instr_count + CNT_W'(1);
            phase_idx_n   = '0;
            if (state == ST_STEP || halt_req || !run) begin
              state_n  = ST_HALT;
              phase_n  = '0;
              halted_n = 1'b1;
            end else begin
              phase_n    = PHASES'(1);
              timer_load = 1'b1;
            end
          end else begin
            phase_idx_n = phase_idx + IDX_W'(1);
            phase_n     = phase << 1;
            timer_load  = 1'b1;
            load_idx    = phase_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_n  = ST_HALT;
        phase_n  = '0;
        halted_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HALT;
      phase       <= '0;
      phase_idx   <= '0;
      cycle_done  <= 1'b0;
      instr_count <= '0;
      halted      <= 1'b1;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      phase_idx   <= phase_idx_n;
      cycle_done  <= cycle_done_n;
      instr_count <= instr_count_n;
      halted      <= halted_n;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (3 phases, 4-bit wait fields, 4-bit counter).
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, halt_req, step_req, ext_wait;
  logic [11:0] wait_cfg;
  logic [2:0]  phase;
  logic [1:0]  phase_idx;
  logic        phase_last, cycle_done, halted;
  logic [3:0]  instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_sequencer #(
    .PHASES (3),
    .WAIT_W (4),
    .CNT_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .ext_wait    (ext_wait),
    .wait_cfg    (wait_cfg),
    .phase       (phase),
    .phase_idx   (phase_idx),
    .phase_last  (phase_last),
    .cycle_done  (cycle_done),
    .instr_count (instr_count),
    .halted      (halted)
  );

  typedef struct {
    logic        run, halt_req, step_req, ext_wait;
    logic [11:0] wcfg;
    logic        e_last;
    logic [2:0]  e_phase;
    logic        e_done;
    logic [3:0]  e_cnt;
    logic        e_halted;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic h, input logic s, input logic x,
                              input logic [11:0] w, input logic l, input logic [2:0] p,
                              input logic d, input logic [3:0] c, input logic hl);
    vec_t v;
    v.run = r; v.halt_req = h; v.step_req = s; v.ext_wait = x; v.wcfg = w;
    v.e_last = l; v.e_phase = p; v.e_done = d; v.e_cnt = c; v.e_halted = hl;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [2:0] p);
    return (p == 3'b100) ? 2'd2 : (p == 3'b010) ? 2'd1 : 2'd0;
  endfunction

  // Advance one edge, then check registered outputs
  task automatic tick_check(input string name, input logic [2:0] p, input logic d,
                            input logic [3:0] c, input logic hl);
    @(posedge clk);
    #1;
    check({name, " phase"}, 32'(phase), 32'(p));
    check({name, " idx"}, 32'(phase_idx), 32'(idx_of(p)));
    check({name, " done"}, 32'(cycle_done), 32'(d));
    check({name, " count"}, 32'(instr_count), 32'(c));
    check({name, " halted"}, 32'(halted), 32'(hl));
  endtask

  initial begin
    logic [3:0] exp_cnt;

    // run, halt, step, ext, wcfg, last(pre-edge), phase, done, count, halted (post-edge)
    add(1,0,0,0,12'h000, 0, 3'b001,0,0,0);
    add(1,0,0,0,12'h000, 1, 3'b010,0,0,0);
    add(1,0,0,0,12'h000, 1, 3'b100,0,0,0);
    add(1,0,0,0,12'h000, 1, 3'b001,1,1,0);
    add(1,0,0,0,12'h000, 1, 3'b010,0,1,0);
    add(1,0,0,0,12'h000, 1, 3'b100,0,1,0);
    add(1,0,0,0,12'h000, 1, 3'b001,1,2,0);
    add(1,0,0,0,12'h000, 1, 3'b010,0,2,0);
    add(1,0,0,0,12'h000, 1, 3'b100,0,2,0);
    add(1,0,0,0,12'h000, 1, 3'b001,1,3,0);
    // phase 1 waits 2 extra cycles
    add(1,0,0,0,12'h020, 1, 3'b010,0,3,0);
    add(1,0,0,0,12'h020, 0, 3'b010,0,3,0);
    add(1,0,0,0,12'h020, 0, 3'b010,0,3,0);
    add(1,0,0,0,12'h020, 1, 3'b100,0,3,0);
    add(1,0,0,0,12'h020, 1, 3'b001,1,4,0);
    add(1,0,0,0,12'h020, 1, 3'b010,0,4,0);
    add(1,0,0,0,12'h020, 0, 3'b010,0,4,0);
    add(1,0,0,0,12'h020, 0, 3'b010,0,4,0);
    add(1,0,0,0,12'h020, 1, 3'b100,0,4,0);
    add(1,0,0,0,12'h020, 1, 3'b001,1,5,0);
    // ext_wait held 4 cycles at zero count
    add(1,0,0,0,12'h000, 1, 3'b010,0,5,0);
    add(1,0,0,0,12'h000, 1, 3'b100,0,5,0);
    add(1,0,0,1,12'h000, 0, 3'b100,0,5,0);
    add(1,0,0,1,12'h000, 0, 3'b100,0,5,0);
    add(1,0,0,1,12'h000, 0, 3'b100,0,5,0);
    add(1,0,0,1,12'h000, 0, 3'b100,0,5,0);
    add(1,0,0,0,12'h000, 1, 3'b001,1,6,0);
    // ext_wait during nonzero wait count has no effect
    add(1,0,0,0,12'h200, 1, 3'b010,0,6,0);
    add(1,0,0,0,12'h200, 1, 3'b100,0,6,0);
    add(1,0,0,1,12'h200, 0, 3'b100,0,6,0);
    add(1,0,0,0,12'h200, 0, 3'b100,0,6,0);
    add(1,0,0,0,12'h200, 1, 3'b001,1,7,0);
    // halt_req mid-instruction completes the cycle first
    add(1,0,0,0,12'h000, 1, 3'b010,0,7,0);
    add(1,1,0,0,12'h000, 1, 3'b100,0,7,0);
    add(1,1,0,0,12'h000, 1, 3'b000,1,8,1);
    add(0,0,0,0,12'h000, 0, 3'b000,0,8,1);
    add(0,0,0,0,12'h000, 0, 3'b000,0,8,1);
    // single step, with a stray step_req while stepping
    add(0,0,1,0,12'h000, 0, 3'b001,0,8,0);
    add(0,0,0,0,12'h000, 1, 3'b010,0,8,0);
    add(0,0,1,0,12'h000, 1, 3'b100,0,8,0);
    add(0,0,0,0,12'h000, 1, 3'b000,1,9,1);
    add(0,0,0,0,12'h000, 0, 3'b000,0,9,1);

    rst = 1'b1; run = 1'b1; halt_req = 1'b0; step_req = 1'b0; ext_wait = 1'b0;
    wait_cfg = 12'h000;
    tick_check("reset0", 3'b000, 0, 0, 1);
    tick_check("reset1", 3'b000, 0, 0, 1);
    check("reset last", 32'(phase_last), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run = vecs[i].run; halt_req = vecs[i].halt_req; step_req = vecs[i].step_req;
      ext_wait = vecs[i].ext_wait; wait_cfg = vecs[i].wcfg;
      #1;
      check($sformatf("v%0d last", i), 32'(phase_last), 32'(vecs[i].e_last));
      tick_check($sformatf("v%0d", i), vecs[i].e_phase, vecs[i].e_done,
                 vecs[i].e_cnt, vecs[i].e_halted);
    end

    // Counter wrap: 9 -> 15 -> 0 -> 1 with no stall
    run = 1'b1; step_req = 1'b0;
    tick_check("wrap start", 3'b001, 0, 9, 0);
    exp_cnt = 4'd9;
    for (int n = 0; n < 8; n++) begin
      tick_check($sformatf("wrap%0d p1", n), 3'b010, 0, exp_cnt, 0);
      tick_check($sformatf("wrap%0d p2", n), 3'b100, 0, exp_cnt, 0);
      exp_cnt = exp_cnt + 4'd1;
      tick_check($sformatf("wrap%0d p0", n), 3'b001, 1, exp_cnt, 0);
    end
    check("wrap final", 32'(instr_count), 32'd1);

    // run dropped mid-instruction: finish it, then halt
    tick_check("rundrop p1", 3'b010, 0, 1, 0);
    run = 1'b0;
    tick_check("rundrop p2", 3'b100, 0, 1, 0);
    tick_check("rundrop halt", 3'b000, 1, 2, 1);

    // Reset mid-phase discards the partial instruction
    run = 1'b1;
    tick_check("mid p0", 3'b001, 0, 2, 0);
    tick_check("mid p1", 3'b010, 0, 2, 0);
    rst = 1'b1;
    tick_check("mid rst", 3'b000, 0, 0, 1);
    #1;
    check("mid rst last", 32'(phase_last), 32'd0);
    rst = 1'b0;
    tick_check("post rst", 3'b001, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised successor to the fixed three-phase clock divisor that drives the CPU's memory and register bank.
- Produces N one-hot execution phases per instruction cycle.
- Adds per-phase programmable wait states, external stall, a run/halt/single-step control FSM and a retired-instruction counter.
- Sits at the CPU top; its phase strobes replace the individual cycle-x/y/z wires fed to memory and registers.

Parameters:
- PHASES, 3, number of phases per instruction cycle (2..8).
- WAIT_W, 4, width of each per-phase wait-state field.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level; continuous execution requested.
- halt_req  input  1  level; stop at the next instruction boundary.
- step_req  input  1  pulse; execute exactly one instruction cycle from HALT.
- ext_wait  input  1  external stall (memory not ready), level.
- wait_cfg  input  PHASES*WAIT_W  extra cycles per phase; field k = bits [k*WAIT_W +: WAIT_W].
- phase  output  PHASES  one-hot active phase, all zero when halted.
- phase_idx  output  $clog2(PHASES)  binary index of the active phase.
- phase_last  output  1  high in the final clock cycle of the current phase (advance cycle).
- cycle_done  output  1  one-cycle pulse after the last phase of an instruction completes.
- instr_count  output  CNT_W  retired instruction count.
- halted  output  1  high while in HALT.

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs except phase_last are registered.
- Reset values: phase=0, phase_idx=0, phase_last=0, cycle_done=0, instr_count=0, halted=1, FSM=HALT.
- FSM states: HALT, RUN, STEP.
  - HALT -> RUN when run=1 at an edge.
  - HALT -> STEP when run=0 and step_req=1.
  - run has priority over step_req.
  - The edge that leaves HALT sets phase=1 (phase 0), phase_idx=0 and halted=0.
- Phase timing:
  - Phase k lasts 1+wait_cfg[k] cycles minimum.
  - wait_cfg[k] is sampled on entry to phase k; later changes do not affect the phase in progress.
  - An internal down-counter loads wait_cfg[k] on entry.
  - phase_last = (counter==0) && !ext_wait && FSM!=HALT.
  - ext_wait is honoured only once the counter has reached 0; it extends the phase one cycle per cycle held high.
  - ext_wait while the counter is nonzero has no effect.
- Advance:
  - When phase_last=1, the next edge moves to phase k+1.
  - From phase PHASES-1 the next edge wraps to phase 0, pulses cycle_done=1 and increments instr_count.
  - instr_count wraps modulo 2^CNT_W with no flag.
- Instruction boundary decision, made at the advance edge out of phase PHASES-1:
  - In STEP: always go to HALT.
  - In RUN: go to HALT if halt_req=1 or run=0, otherwise continue.
  - On entering HALT: phase=0, halted=1; cycle_done still pulses on that edge.
- halt_req and run=0 never truncate an instruction mid-cycle.
- step_req is ignored outside HALT.
- rst mid-phase: all state returns to reset values at that edge; the partial instruction is not counted.
- PHASES=1 is not supported. An implementation may assert this at elaboration.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_HALT=2'd0, ST_RUN=2'd1, ST_STEP=2'd2).
  - Default PHASES/WAIT_W/CNT_W constants, reused by the CPU top.
- One natural sub-module: phase_wait_timer.
  - Loadable WAIT_W down-counter with ext_wait gating.
  - Output: expired/last indication.
  - Instantiated once.

Test Plan:
- Reset: hold rst 2 cycles with run=1 -> halted=1, phase=0, instr_count=0 throughout; release -> phase=3'b001 on the next edge.
- PHASES=3, wait_cfg=0, run=1:
  - phase sequence 001,010,100,001… one cycle each.
  - cycle_done pulses every 3 cycles, coincident with phase 001.
  - instr_count reads 1,2,3 after 3 instructions.
- wait_cfg field1=2, others 0 -> phase 010 held exactly 3 cycles; instruction period 5 cycles.
- ext_wait high 4 cycles starting when phase 100 has counter 0 -> phase 100 lasts 5 cycles; ext_wait pulsed during a nonzero wait count -> no extension.
- Run-time halt and step:
  - halt_req asserted during phase 010 -> phases 010 and 100 complete, cycle_done pulses, then halted=1, phase=0; count incremented once.
  - step_req pulse from HALT -> exactly one 3-phase cycle, then halted=1.
- CNT_W=4, run for 17 instructions -> instr_count 15 -> 0 -> 1, no stall or glitch at wrap.
